// File: rtl/rps_match_n.sv
// N-player rock-paper-scissors match engine: gathers one move per player per round,
// scores every pair, keeps saturating per-player totals and reports the match winner.
module rps_match_n #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 8,
  parameter int ROUNDS      = 16,
  parameter int BUSY_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PLAYERS-1:0]         r,
  input  logic [NUM_PLAYERS-1:0]         p,
  input  logic [NUM_PLAYERS-1:0]         s,
  input  logic [NUM_PLAYERS-1:0]         go,
  input  logic                           new_match,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic                           dut_busy,
  output logic [15:0]                    round_cnt,
  output logic                           match_done,
  output logic [2:0]                     winner,
  output logic                           tie
);

  localparam int BW    = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
  localparam int SUM_W = SCORE_W + 4;
  localparam logic [SCORE_W-1:0] SAT     = '1;
  localparam logic [SUM_W-1:0]   SAT_EXT = SUM_W'(SAT);

  typedef enum logic [1:0] {COLLECT, EVAL, DONE} state_t;

  state_t                                state_q, state_d;
  logic [NUM_PLAYERS-1:0]                armed_q, armed_d;
  logic [NUM_PLAYERS-1:0][2:0]           mv_q, mv_d;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0]   score_q, score_d;
  logic                                  busy_q, busy_d;
  logic [BW-1:0]                         bcnt_q, bcnt_d;
  logic [15:0]                           round_q, round_d;
  logic                                  done_q, done_d;
  logic [2:0]                            winner_q, winner_d;
  logic                                  tie_q, tie_d;

  // Moves are held as {r,p,s}; exactly one bit set is the only legal encoding.
  function automatic logic valid_mv(input logic [2:0] m);
    return (m == 3'b100) || (m == 3'b010) || (m == 3'b001);
  endfunction

  function automatic logic beats(input logic [2:0] a, input logic [2:0] b);
    return valid_mv(a) && (!valid_mv(b) ||
                           (a == 3'b100 && b == 3'b001) ||
                           (a == 3'b010 && b == 3'b100) ||
                           (a == 3'b001 && b == 3'b010));
  endfunction

  logic [NUM_PLAYERS-1:0][SCORE_W-1:0] nscore;
  logic [SCORE_W-1:0]                  best;
  logic [2:0]                          nwinner;
  logic                                ntie;
  logic [3:0]                          wins;
  logic [3:0]                          ntop;
  logic [SUM_W-1:0]                    sum;

  // Candidate end-of-round scores and the standings they would produce.
  always_comb begin
    nscore  = score_q;
    wins    = '0;
    sum     = '0;
    best    = '0;
    nwinner = '0;
    ntop    = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      wins = '0;
      for (int j = 0; j < NUM_PLAYERS; j++) begin
        if (j != i && beats(mv_q[i], mv_q[j])) wins = wins + 4'd1;
      end
      sum       = SUM_W'(score_q[i]) + SUM_W'(wins);
      nscore[i] = (sum > SAT_EXT) ? SAT : sum[SCORE_W-1:0];
    end
    best = nscore[0];
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if (nscore[i] > best) begin
        best    = nscore[i];
        nwinner = 3'(i);
      end
    end
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (nscore[i] == best) ntop = ntop + 4'd1;
    end
    ntie = (ntop > 4'd1);
  end

  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q;
    mv_d     = mv_q;
    score_d  = score_q;
    busy_d   = busy_q;
    bcnt_d   = bcnt_q;
    round_d  = round_q;
    done_d   = done_q;
    winner_d = winner_q;
    tie_d    = tie_q;
    if (new_match) begin
      state_d  = COLLECT;
      armed_d  = '0;
      score_d  = '0;
      busy_d   = 1'b0;
      bcnt_d   = '0;
      round_d  = '0;
      done_d   = 1'b0;
      winner_d = '0;
      tie_d    = 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (&armed_q) begin
            state_d = EVAL;
            busy_d  = 1'b1;
            bcnt_d  = BW'(BUSY_CYCLES - 1);
          end else begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
              if (go[i] && !armed_q[i]) begin
                armed_d[i] = 1'b1;
                mv_d[i]    = {r[i], p[i], s[i]};
              end
            end
          end
        end
        EVAL: begin
          if (bcnt_q == '0) begin
            busy_d  = 1'b0;
            armed_d = '0;
            score_d = nscore;
            round_d = (round_q == 16'hFFFF) ? round_q : round_q + 16'd1;
            if (ROUNDS != 0 && round_d == 16'(ROUNDS)) begin
              state_d  = DONE;
              done_d   = 1'b1;
              winner_d = nwinner;
              tie_d    = ntie;
            end else begin
              state_d = COLLECT;
            end
          end else begin
            bcnt_d = bcnt_q - BW'(1);
          end
        end
        DONE:    state_d = DONE;
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= COLLECT;
      armed_q  <= '0;
      mv_q     <= '0;
      score_q  <= '0;
      busy_q   <= 1'b0;
      bcnt_q   <= '0;
      round_q  <= '0;
      done_q   <= 1'b0;
      winner_q <= '0;
      tie_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      mv_q     <= mv_d;
      score_q  <= score_d;
      busy_q   <= busy_d;
      bcnt_q   <= bcnt_d;
      round_q  <= round_d;
      done_q   <= done_d;
      winner_q <= winner_d;
      tie_q    <= tie_d;
    end
  end

  assign score      = score_q;
  assign dut_busy   = busy_q;
  assign round_cnt  = round_q;
  assign match_done = done_q;
  assign winner     = winner_q;
  assign tie        = tie_q;

endmodule
